// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a W-bit pattern out MSB-first, repeated
// repeat_cnt times with an optional idle gap between repetitions.
module seq_pattern_tx #(
  parameter int W     = 5,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             dout,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start, all outputs low
  // SEND  | shifting pattern bits onto dout
  // GAP   | idle spacing between two repetitions
  // DONE  | single-cycle completion pulse
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int IDX_W = $clog2(W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

  logic [1:0]       state_q,   state_d;
  logic [W-1:0]     shreg_q,   shreg_d;
  logic [W-1:0]     pat_q,     pat_d;
  logic [CNT_W-1:0] reps_q,    reps_d;
  logic [GAP_W-1:0] gap_reg_q, gap_reg_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0] idx_q,     idx_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    reps_d    = reps_q;
    gap_reg_d = gap_reg_q;
    gap_cnt_d = gap_cnt_q;
    idx_d     = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = pattern;
          pat_d     = pattern;
          reps_d    = repeat_cnt;
          gap_reg_d = gap_len;
          idx_d     = IDX_LAST;
          state_d   = (repeat_cnt != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        shreg_d = shreg_q << 1;
        idx_d   = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          reps_d = reps_q - CNT_W'(1);
          if (reps_q == CNT_W'(1)) begin
            state_d = DONE;
          end else if (gap_reg_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_reg_q;
          end else begin
            shreg_d = pat_q;
            idx_d   = IDX_LAST;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = SEND;
          shreg_d = pat_q;
          idx_d   = IDX_LAST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      reps_q    <= '0;
      gap_reg_q <= '0;
      gap_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      reps_q    <= reps_d;
      gap_reg_q <= gap_reg_d;
      gap_cnt_q <= gap_cnt_d;
      idx_q     <= idx_d;
    end
  end

  // Outputs decode from state/shift register only, so reset clears them at once.
  assign dout  = (state_q == SEND) & shreg_q[W-1];
  assign valid = (state_q == SEND);
  assign busy  = (state_q == SEND) | (state_q == GAP);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx, including loopback into an 11011
// Moore detector model.
module tb_seq_pattern_tx;
  localparam int W = 5, CNT_W = 8, GAP_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic [GAP_W-1:0] gap_len = '0;
  logic dout, valid, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.W(W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .gap_len(gap_len),
    .dout(dout), .valid(valid), .busy(busy), .done(done)
  );

  // 11011 overlapping Moore detector fed by dout
  logic [2:0] det_q;
  logic det;
  always @(posedge clk or posedge rst) begin
    if (rst) det_q <= 3'd0;
    else begin
      case (det_q)
        3'd0: det_q <= dout ? 3'd1 : 3'd0;
        3'd1: det_q <= dout ? 3'd2 : 3'd0;
        3'd2: det_q <= dout ? 3'd2 : 3'd3;
        3'd3: det_q <= dout ? 3'd4 : 3'd0;
        3'd4: det_q <= dout ? 3'd5 : 3'd0;
        default: det_q <= dout ? 3'd2 : 3'd3;
      endcase
    end
  end
  assign det = (det_q == 3'd5);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [W-1:0] pat, input logic [CNT_W-1:0] rc,
                          input logic [GAP_W-1:0] gl);
    pattern = pat;
    repeat_cnt = rc;
    gap_len = gl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dout"}, {31'd0, dout}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [W-1:0] exp_pat);
    for (int i = 0; i < W; i++) begin
      check({tag, "_dout"}, {31'd0, dout}, {31'd0, exp_pat[W-1-i]});
      check({tag, "_valid"}, {31'd0, valid}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_valid"}, {31'd0, valid}, 32'd0);
    tick();
    check_idle({tag, "_after"});
  endtask

  initial begin
    logic [18:0] exp_v;
    logic [18:0] exp_d;
    logic [10:0] exp_v2;
    logic [10:0] exp_d2;
    int nv, ndone, cyc, nones;

    #3;
    check_idle("reset");
    #9 rst = 1'b0;
    tick();
    check_idle("post_reset");

    // basic single frame
    start_tx(5'b11011, 8'd1, 4'd0);
    check_frame("basic", 5'b11011);

    // three repetitions with a two-cycle gap
    exp_v = 19'b1111100111110011111;
    exp_d = 19'b1101100110110011011;
    nv = 0;
    start_tx(5'b11011, 8'd3, 4'd2);
    for (int i = 0; i < 19; i++) begin
      check("rg_valid", {31'd0, valid}, {31'd0, exp_v[18-i]});
      check("rg_dout", {31'd0, dout}, {31'd0, exp_d[18-i]});
      check("rg_busy", {31'd0, busy}, 32'd1);
      check("rg_done_early", {31'd0, done}, 32'd0);
      nv += int'(valid);
      tick();
    end
    check("rg_done", {31'd0, done}, 32'd1);
    check("rg_nvalid", nv, 32'd15);
    tick();
    check_idle("rg_after");

    // zero repetitions
    start_tx(5'b11111, 8'd0, 4'd3);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_valid", {31'd0, valid}, 32'd0);
    check("zero_busy", {31'd0, busy}, 32'd0);
    tick();
    check_idle("zero_after");

    // start and pattern changes while busy are ignored
    exp_v2 = 11'b11111011111;
    exp_d2 = 11'b11011011011;
    ndone = 0;
    start_tx(5'b11011, 8'd2, 4'd1);
    for (int i = 0; i < 11; i++) begin
      if (i == 1) begin start = 1'b1; pattern = 5'b10101; repeat_cnt = 8'd7; gap_len = 4'd9; end
      if (i == 2) start = 1'b0;
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
      check("busy_valid", {31'd0, valid}, {31'd0, exp_v2[10-i]});
      check("busy_dout", {31'd0, dout}, {31'd0, exp_d2[10-i]});
      ndone += int'(done);
      tick();
    end
    check("busy_done", {31'd0, done}, 32'd1);
    ndone += int'(done);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("busy_post_valid", {31'd0, valid}, 32'd0);
      check("busy_post_busy", {31'd0, busy}, 32'd0);
      ndone += int'(done);
      tick();
    end
    check("busy_ndone", ndone, 32'd1);

    // asynchronous reset during bit 3
    start_tx(5'b11111, 8'd1, 4'd0);
    tick();
    tick();
    check("rst_pre_dout", {31'd0, dout}, 32'd1);
    check("rst_pre_valid", {31'd0, valid}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check_idle("rst_async");
    tick();
    check_idle("rst_held");
    #2 rst = 1'b0;
    tick();
    check_idle("rst_release");
    start_tx(5'b11011, 8'd1, 4'd0);
    check_frame("rst_fresh", 5'b11011);

    // loopback into the 11011 detector
    start_tx(5'b11011, 8'd2, 4'd0);
    for (int i = 1; i <= 12; i++) begin
      check("loop_det", {31'd0, det}, (i == 6 || i == 11) ? 32'd1 : 32'd0);
      tick();
    end

    // maximum repeat count and gap length
    nv = 0;
    cyc = 0;
    nones = 0;
    start_tx(5'b10000, 8'd255, 4'd15);
    while (!done && cyc < 6000) begin
      nv += int'(valid);
      nones += int'(dout);
      cyc++;
      tick();
    end
    check("max_cycles", cyc, 32'd5085);
    check("max_nvalid", nv, 32'd1275);
    check("max_nones", nones, 32'd255);
    check("max_done", {31'd0, done}, 32'd1);
    tick();
    check_idle("max_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the generating end of our serial bit-sequence detection path.
- Serializes a W-bit pattern MSB-first onto a 1-bit line, one bit per clock.
- Supports a programmable repeat count and an idle gap between repetitions.
- Default configuration emits 11011 frames that feed the team's 11011 Moore sequence detector for stimulus and loopback testing.

Parameters:
- W, 5, pattern width in bits (>=2).
- CNT_W, 8, width of repeat-count input.
- GAP_W, 4, width of inter-repetition gap-length input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request transmission; sampled only in IDLE.
- pattern  input  W  bits to send, MSB first.
- repeat_cnt  input  CNT_W  number of pattern repetitions; 0 = none.
- gap_len  input  GAP_W  idle cycles between repetitions; 0 = back-to-back.
- dout  output  1  serial data bit.
- valid  output  1  dout carries a pattern bit this cycle.
- busy  output  1  transmission in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Single clock domain; one clock and one reset as already decided.
- rst=1 immediately forces: state IDLE, dout=0, valid=0, busy=0, done=0, all counters and the shift register to 0.
- Reset mid-transmission aborts with no done pulse.
- Moore machine: dout/valid/busy/done are registered, or decoded from state and shift register only. No combinational input-to-output path.
- States: IDLE, SEND, GAP, DONE.
- IDLE: outputs 0.
  - start=1 at an edge latches pattern into the shift register, repeat_cnt into reps, and gap_len into gap_reg.
  - If repeat_cnt!=0: go to SEND and load bit index W-1.
  - If repeat_cnt==0: go to DONE.
- SEND: dout=shreg[W-1], valid=1, busy=1.
  - Each edge: shift left by 1 and decrement the bit index.
  - On the edge where the index is 0 (last bit sent), decrement reps, then:
    - reps was 1: go to DONE.
    - Otherwise, gap_reg!=0: go to GAP and load the gap counter with gap_reg.
    - Otherwise: stay in SEND, reload the shift register from the latched pattern copy, reset the index to W-1.
- GAP: dout=0, valid=0, busy=1.
  - Counter decrements each edge; on the edge where it reaches 1, go to SEND with the pattern reloaded and index W-1.
  - Exactly gap_reg cycles of GAP.
  - GAP never occurs after the final repetition.
- DONE: done=1, busy=0, valid=0, dout=0, for exactly one cycle, then IDLE.
- Latency: the first bit is on dout in the cycle after the edge that samples start.
- Total cycles with valid=1 = W*repeat_cnt.
- start is ignored in SEND, GAP and DONE.
- Inputs pattern, repeat_cnt and gap_len are don't-care after the start edge; they are latched.
- A new start may be accepted the cycle after DONE (in IDLE).
- Counters never wrap. repeat_cnt=2^CNT_W-1 and gap_len=2^GAP_W-1 must work.

Test Plan:
- Basic frame: reset, pattern=11011, repeat_cnt=1, gap_len=0, start pulse.
  - Next 5 cycles: dout=1,1,0,1,1 with valid=1, busy=1.
  - Cycle 6: done=1.
  - Cycle 7: IDLE, all outputs 0.
- Repeat with gap: pattern=11011, repeat_cnt=3, gap_len=2.
  - valid pattern 5 on, 2 off, 5 on, 2 off, 5 on (19 cycles, dout=0 in gaps).
  - done in the 20th cycle; 15 valid bits total.
- Zero repeats: repeat_cnt=0, start.
  - valid never asserts; done=1 in the cycle after start; busy stays 0.
- Start while busy and input change: pulse start again and change pattern to 10101 mid-frame.
  - Output stream unchanged (still 11011 frames).
  - Exactly one done pulse.
- Async reset mid-SEND: assert rst between clock edges during bit 3.
  - dout/valid/busy drop to 0 before the next edge; no done.
  - After release, a fresh start transmits normally.
- Loopback: dout drives the 11011 Moore sequence detector; repeat_cnt=2, gap_len=0, stream 1101111011.
  - Detector output asserts twice: the cycle after bit 5 and the cycle after bit 10.
